// File: rtl/acia_loader.sv
// acia_loader: serial boot loader that polls an ACIA for framed download
// records and writes their payload into memory.
//
// Frame: SYNC_BYTE, addr_hi, addr_lo, count (0 = 256), data[count], csum.
// The frame is good when the 8-bit sum of addr_hi, addr_lo, count, data and
// csum is zero. ACK_BYTE or NAK_BYTE is then written back through the ACIA.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   enable         loader runs while high; low parks the bus FSM in IDLE
//   acia_rd/wr     one-cycle ACIA read/write strobes
//   acia_regSel    00 = RX/TX data, 01 = status (00 when no strobe)
//   acia_dataIn    byte written to the ACIA
//   acia_dataOut   ACIA read data, valid the cycle after acia_rd
//                  (status bit0 = RX available, bit1 = TX not full)
//   mem_we/addr/wdata  one-cycle memory write of each payload byte
//   busy           frame in progress (past SYNC), including the reply
//   done / error   one-cycle pulses on ACK write / on NAK write or timeout
module acia_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        acia_rd,
  output logic        acia_wr,
  output logic [1:0]  acia_regSel,
  output logic [7:0]  acia_dataIn,
  input  logic [7:0]  acia_dataOut,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);

  typedef enum logic [3:0] {
    IDLE, RX_STAT, RX_STAT_W, RX_DATA, RX_DATA_W,
    PROCESS, TX_STAT, TX_STAT_W, TX_WRITE
  } state_t;

  typedef enum logic [2:0] {
    PH_SYNC, PH_AH, PH_AL, PH_CNT, PH_DATA, PH_CSUM
  } phase_t;

  state_t        state;
  phase_t        phase;
  logic [15:0]   ptr;
  logic [8:0]    cnt;
  logic [7:0]    csum;
  logic [7:0]    rx_byte;
  logic [7:0]    reply;
  logic          reply_good;
  logic [TW-1:0] tmo;

  logic [7:0] csum_next;
  logic       in_tx;

  assign csum_next = csum + rx_byte;
  assign in_tx     = (state == TX_STAT) || (state == TX_STAT_W) || (state == TX_WRITE);
  assign busy      = (phase != PH_SYNC);

  // Strobes are registered: each is raised on the transition into the state
  // that owns it, so it is high for exactly that state's single cycle.
  always_ff @(posedge clk) begin
    acia_rd     <= 1'b0;
    acia_wr     <= 1'b0;
    acia_regSel <= 2'b00;
    mem_we      <= 1'b0;
    done        <= 1'b0;
    error       <= 1'b0;

    if (reset) begin
      state       <= IDLE;
      phase       <= PH_SYNC;
      ptr         <= '0;
      cnt         <= '0;
      csum        <= '0;
      rx_byte     <= '0;
      reply       <= '0;
      reply_good  <= 1'b0;
      tmo         <= '0;
      acia_dataIn <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else if (!enable) begin
      state <= IDLE;
      phase <= PH_SYNC;
      tmo   <= '0;
    end else begin
      // Timeout counter; the state handling below clears it on accepted bytes.
      if (phase == PH_SYNC)
        tmo <= '0;
      else if (!in_tx && (tmo != TMO_LIMIT))
        tmo <= tmo + TMO_ONE;

      unique case (state)
        IDLE: begin
          state       <= RX_STAT;
          acia_rd     <= 1'b1;
          acia_regSel <= 2'b01;
        end
        RX_STAT: state <= RX_STAT_W;
        RX_STAT_W: begin
          // Expiry is acted on here: the counter saturates, and aborting from
          // a strobe-free state keeps every rd strobe one cycle wide.
          if (tmo == TMO_LIMIT) begin
            error       <= 1'b1;
            phase       <= PH_SYNC;
            tmo         <= '0;
            state       <= RX_STAT;
            acia_rd     <= 1'b1;
            acia_regSel <= 2'b01;
          end else if (acia_dataOut[0]) begin
            state       <= RX_DATA;
            acia_rd     <= 1'b1;
            acia_regSel <= 2'b00;
          end else begin
            state       <= RX_STAT;
            acia_rd     <= 1'b1;
            acia_regSel <= 2'b01;
          end
        end
        RX_DATA: state <= RX_DATA_W;
        RX_DATA_W: begin
          rx_byte <= acia_dataOut;
          tmo     <= '0;
          state   <= PROCESS;
          // Payload write is issued here so mem_we occupies the PROCESS cycle.
          if (phase == PH_DATA) begin
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= acia_dataOut;
          end
        end
        PROCESS: begin
          state       <= RX_STAT;
          acia_rd     <= 1'b1;
          acia_regSel <= 2'b01;
          unique case (phase)
            PH_SYNC: begin
              if (rx_byte == SYNC_BYTE) begin
                phase <= PH_AH;
                csum  <= '0;
              end
            end
            PH_AH: begin
              ptr[15:8] <= rx_byte;
              csum      <= csum_next;
              phase     <= PH_AL;
            end
            PH_AL: begin
              ptr[7:0] <= rx_byte;
              csum     <= csum_next;
              phase    <= PH_CNT;
            end
            PH_CNT: begin
              cnt   <= (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
              csum  <= csum_next;
              phase <= PH_DATA;
            end
            PH_DATA: begin
              ptr  <= ptr + 16'd1;
              cnt  <= cnt - 9'd1;
              csum <= csum_next;
              if (cnt == 9'd1) phase <= PH_CSUM;
            end
            PH_CSUM: begin
              reply_good <= (csum_next == 8'd0);
              reply      <= (csum_next == 8'd0) ? ACK_BYTE : NAK_BYTE;
              state      <= TX_STAT;
            end
            default: phase <= PH_SYNC;
          endcase
        end
        TX_STAT: state <= TX_STAT_W;
        TX_STAT_W: begin
          if (acia_dataOut[1]) begin
            state       <= TX_WRITE;
            acia_wr     <= 1'b1;
            acia_regSel <= 2'b00;
            acia_dataIn <= reply;
            done        <= reply_good;
            error       <= !reply_good;
          end else begin
            state       <= TX_STAT;
            acia_rd     <= 1'b1;
            acia_regSel <= 2'b01;
          end
        end
        TX_WRITE: begin
          phase       <= PH_SYNC;
          state       <= RX_STAT;
          acia_rd     <= 1'b1;
          acia_regSel <= 2'b01;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acia_loader.sv
module tb_acia_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        acia_rd, acia_wr;
  logic [1:0]  acia_regSel;
  logic [7:0]  acia_dataIn;
  logic [7:0]  acia_dataOut = 8'h00;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy, done, error;

  always #5 clk = ~clk;

  acia_loader #(
    .SYNC_BYTE(8'hA5), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15), .TIMEOUT_CYCLES(300)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .acia_rd(acia_rd), .acia_wr(acia_wr), .acia_regSel(acia_regSel),
    .acia_dataIn(acia_dataIn), .acia_dataOut(acia_dataOut),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error)
  );

  logic [7:0]  rxq[$];      // bytes the ACIA will deliver
  logic [23:0] exp_mem[$];  // expected {addr, data} writes
  logic [7:0]  exp_tx[$];   // expected reply bytes
  int          exp_evt[$];  // 1 = done pulse, 2 = error pulse
  int compared = 0, mismatched = 0;
  bit rx_rand = 0, tx_rand = 0, tx_ready = 1;
  int stat_polls = 0;
  logic prev_rd = 0, prev_wr = 0;
  logic [7:0] fr[0:255];

  // Behavioural ACIA: registered read data one cycle after acia_rd.
  always @(posedge clk) begin
    if (acia_rd) begin
      if (acia_regSel == 2'b01)
        acia_dataOut <= {6'd0,
                         tx_ready && (!tx_rand || $urandom_range(0, 1) == 1),
                         (rxq.size() != 0) && (!rx_rand || $urandom_range(0, 3) != 0)};
      else if (rxq.size() != 0)
        acia_dataOut <= rxq.pop_front();
      else
        acia_dataOut <= 8'h00;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (acia_rd && acia_wr) check("rd_wr_overlap", 32'd1, 32'd0);
      if (acia_rd) begin
        check("rd_width", {31'd0, prev_rd}, 32'd0);
        if (acia_regSel == 2'b01) stat_polls++;
      end
      if (acia_wr) begin
        check("wr_width", {31'd0, prev_wr}, 32'd0);
        check("wr_regsel", {30'd0, acia_regSel}, 32'd0);
        if (exp_tx.size() == 0) check("unexpected_tx", {24'd0, acia_dataIn}, 32'hFFFF_FFFF);
        else check("tx_byte", {24'd0, acia_dataIn}, {24'd0, exp_tx.pop_front()});
      end
      if (!acia_rd && !acia_wr) check("idle_regsel", {30'd0, acia_regSel}, 32'd0);
      if (mem_we) begin
        if (exp_mem.size() == 0) check("unexpected_write", {8'd0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
        else check("mem_write", {8'd0, mem_addr, mem_wdata}, {8'd0, exp_mem.pop_front()});
      end
      if (done) begin
        if (exp_evt.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else check("done_event", 32'd1, exp_evt.pop_front());
      end
      if (error) begin
        if (exp_evt.size() == 0) check("unexpected_error", 32'd2, 32'd0);
        else check("error_event", 32'd2, exp_evt.pop_front());
      end
    end
    prev_rd <= acia_rd;
    prev_wr <= acia_wr;
  end

  function automatic logic [7:0] frame_sum(input logic [15:0] a, input int n);
    logic [7:0] s;
    s = a[15:8] + a[7:0] + 8'(n);
    for (int i = 0; i < n; i++) s = s + fr[i];
    return s;
  endfunction

  // Queue a frame (payload taken from fr[]) and its expected effects.
  task automatic send_frame(input logic [15:0] a, input int n, input logic [7:0] cs, input int prefix);
    logic [7:0] g;
    logic [7:0] t;
    for (int i = 0; i < prefix; i++) begin
      do g = 8'($urandom_range(0, 255)); while (g == 8'hA5);
      rxq.push_back(g);
    end
    rxq.push_back(8'hA5);
    rxq.push_back(a[15:8]);
    rxq.push_back(a[7:0]);
    rxq.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      rxq.push_back(fr[i]);
      exp_mem.push_back({a + 16'(i), fr[i]});
    end
    rxq.push_back(cs);
    t = frame_sum(a, n) + cs;
    if (t == 8'd0) begin exp_tx.push_back(8'h06); exp_evt.push_back(1); end
    else begin exp_tx.push_back(8'h15); exp_evt.push_back(2); end
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (!(rxq.size() == 0 && exp_mem.size() == 0 && exp_tx.size() == 0 &&
             exp_evt.size() == 0 && !busy) && k < 30000) begin
      @(posedge clk); #2; k++;
    end
    check({nm, "_timeout"}, (k >= 30000) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic wait_mem_empty(input string nm);
    int k = 0;
    while (exp_mem.size() != 0 && k < 30000) begin @(posedge clk); #2; k++; end
    check({nm, "_timeout"}, (k >= 30000) ? 32'd1 : 32'd0, 32'd0);
  endtask

  initial begin
    int p0, n, strobes;
    logic [15:0] a;
    logic [7:0]  cs;
    reset = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd", {31'd0, acia_rd}, 32'd0);
    check("rst_wr", {31'd0, acia_wr}, 32'd0);
    check("rst_regsel", {30'd0, acia_regSel}, 32'd0);
    check("rst_datain", {24'd0, acia_dataIn}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    reset = 1'b0;
    enable = 1'b1;

    // Good frame, then same frame with a bad checksum.
    fr[0] = 8'h11; fr[1] = 8'h22; fr[2] = 8'h33;
    send_frame(16'h0200, 3, 8'h95, 0);
    wait_idle("good_frame");
    send_frame(16'h0200, 3, 8'h94, 0);
    wait_idle("bad_frame");

    // Leading junk and address wrap.
    rxq.push_back(8'h00);
    rxq.push_back(8'h7F);
    fr[0] = 8'hAA; fr[1] = 8'hBB;
    send_frame(16'hFFFF, 2, 8'h9B, 0);
    wait_idle("wrap_frame");

    // Inter-byte timeout inside a frame.
    rxq.push_back(8'hA5); rxq.push_back(8'h12); rxq.push_back(8'h00);
    exp_evt.push_back(2);
    wait_idle("timeout");
    check("timeout_busy", {31'd0, busy}, 32'd0);
    fr[0] = 8'h5A;
    send_frame(16'h1234, 1, 8'(0 - frame_sum(16'h1234, 1)), 0);
    wait_idle("after_timeout");

    // TX full at reply time: polling continues, no write until bit1 set.
    tx_ready = 1'b0;
    fr[0] = 8'h01; fr[1] = 8'h02;
    send_frame(16'h4000, 2, 8'(0 - frame_sum(16'h4000, 2)), 0);
    wait_mem_empty("txfull_data");
    p0 = stat_polls;
    repeat (150) @(posedge clk);
    #2;
    check("txfull_no_wr", exp_tx.size(), 32'd1);
    check("txfull_polling", (stat_polls - p0 > 20) ? 32'd1 : 32'd0, 32'd1);
    tx_ready = 1'b1;
    wait_idle("txfull_release");

    // enable low: no strobes.
    @(negedge clk) enable = 1'b0;
    @(posedge clk); #2;
    strobes = 0;
    repeat (8) begin @(posedge clk); #2; if (acia_rd || acia_wr) strobes++; end
    check("disabled_strobes", strobes, 32'd0);
    @(negedge clk) enable = 1'b1;

    // Reset mid-frame: the written byte stays, no reply is sent.
    rxq.push_back(8'hA5); rxq.push_back(8'h01); rxq.push_back(8'h02);
    rxq.push_back(8'h05); rxq.push_back(8'h11);
    exp_mem.push_back({16'h0102, 8'h11});
    wait_mem_empty("midframe_data");
    @(negedge clk) reset = 1'b1;
    rxq.delete();
    repeat (3) @(negedge clk);
    check("midframe_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    fr[0] = 8'hC3;
    send_frame(16'h0300, 1, 8'(0 - frame_sum(16'h0300, 1)), 1);
    wait_idle("after_reset");

    // Randomized frames with random ACIA readiness.
    rx_rand = 1;
    tx_rand = 1;
    for (int f = 0; f < 25; f++) begin
      n = (f == 10) ? 256 : $urandom_range(1, 12);
      a = 16'($urandom);
      for (int i = 0; i < n; i++) fr[i] = 8'($urandom);
      cs = 8'(0 - frame_sum(a, n));
      if ($urandom_range(0, 2) == 0) cs = cs + 8'($urandom_range(1, 255));
      send_frame(a, n, cs, $urandom_range(0, 3));
      wait_idle("random_frame");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/acia_loader.md
ACIA_LOADER -- requirements
Module: acia_loader

Interface
REQ-001 Parameter SYNC_BYTE, 8'hA5, frame start marker.
REQ-002 Parameter ACK_BYTE, 8'h06, sent after a good frame.
REQ-003 Parameter NAK_BYTE, 8'h15, sent after a bad-checksum frame.
REQ-004 Parameter TIMEOUT_CYCLES, 1000000, max idle clocks between bytes inside a frame.
REQ-005 clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  loader runs while high.
REQ-008 acia_rd  output  1  one-cycle read strobe to the ACIA.
REQ-009 acia_wr  output  1  one-cycle write strobe to the ACIA.
REQ-010 acia_regSel  output  2  register select: 00 = RX/TX data, 01 = status.
REQ-011 acia_dataIn  output  8  TX byte presented to the ACIA.
REQ-012 acia_dataOut  input  8  ACIA registered read data, valid the cycle after acia_rd; status bit0 = RX byte available, bit1 = TX not full.
REQ-013 mem_we  output  1  one-cycle memory write strobe.
REQ-014 mem_addr  output  16  memory write address.
REQ-015 mem_wdata  output  8  memory write data.
REQ-016 busy  output  1  high while the parser is past SYNC, including the reply.
REQ-017 done  output  1  one-cycle pulse when ACK is written.
REQ-018 error  output  1  one-cycle pulse on NAK write or on timeout.

Function
REQ-019 Frame format SHALL be SYNC_BYTE, addr_hi, addr_lo, count, count data bytes, csum; count 0 SHALL mean 256 bytes.
REQ-020 Bus FSM states SHALL be IDLE, RX_STAT, RX_STAT_W, RX_DATA, RX_DATA_W, PROCESS, TX_STAT, TX_STAT_W, TX_WRITE.
REQ-021 At most one of acia_rd/acia_wr SHALL be high in any cycle; each strobe SHALL last exactly one cycle, with regSel and dataIn valid in that cycle.
REQ-022 When no strobe is active, acia_regSel SHALL be 00.
REQ-023 RX_STAT: rd with regSel 01 -> RX_STAT_W: sample bit0; if 1 -> RX_DATA, else -> RX_STAT.
REQ-024 RX_DATA: rd with regSel 00 -> RX_DATA_W: latch the byte -> PROCESS.
REQ-025 Parser phases SHALL be SYNC, AH, AL, CNT, DATA, CSUM.
REQ-026 PROCESS in SYNC: a byte equal to SYNC_BYTE -> AH; any other byte SHALL be discarded silently.
REQ-027 PROCESS in AH/AL/CNT: load pointer high/low byte and remaining count, then advance phase.
REQ-028 PROCESS in DATA: mem_we high for this single cycle with mem_addr = pointer and mem_wdata = byte.
REQ-029 After each DATA write, the pointer SHALL increment modulo 2^16 (FFFF wraps to 0000) and the count SHALL decrement; at zero the phase SHALL go to CSUM.
REQ-030 Data bytes SHALL be written to memory as received; a NAK does not undo those writes.
REQ-031 Checksum accumulator SHALL be the 8-bit sum mod 256 of addr_hi, addr_lo, count and all data bytes.
REQ-032 CSUM: the frame is good if (sum + csum) mod 256 == 0; the FSM SHALL then go to TX_STAT with reply ACK_BYTE if good, else NAK_BYTE.
REQ-033 TX_STAT: rd with regSel 01 -> TX_STAT_W: if bit1 is 1 -> TX_WRITE, else -> TX_STAT.
REQ-034 TX_WRITE: wr with regSel 00 and dataIn = reply; done pulse if ACK, error pulse if NAK; phase -> SYNC, FSM -> RX_STAT.
REQ-035 From PROCESS with no reply pending, the FSM SHALL go to RX_STAT.
REQ-036 Timeout counter: cleared on every accepted byte; counts only while phase is not SYNC and the FSM is not in the TX states.
REQ-037 On reaching TIMEOUT_CYCLES: error pulse, phase -> SYNC, FSM -> RX_STAT, no TX write.
REQ-038 enable low: the FSM SHALL be in IDLE next cycle, phase SYNC, no strobes issued; a byte already popped is lost.
REQ-039 enable high in IDLE -> RX_STAT next cycle.
REQ-040 Minimum cost SHALL be 5 clocks per received byte (RX_STAT, RX_STAT_W, RX_DATA, RX_DATA_W, PROCESS).

Reset
REQ-041 On reset, the FSM SHALL be IDLE, phase SYNC, and pointer, count, checksum and timeout counter SHALL be 0.
REQ-042 On reset, acia_rd, acia_wr, mem_we, busy, done and error SHALL be 0, acia_regSel 00, acia_dataIn 00, mem_addr 0000, mem_wdata 00.
REQ-043 Reset mid-frame SHALL abandon the frame without any TX write.

Verification
REQ-044 RX A5 02 00 03 11 22 33 95 -> writes 11@0200, 22@0201, 33@0202; ACK 06 written; one done pulse.
REQ-045 Same frame with csum 94 -> the same three writes; NAK 15 written; one error pulse; no done.
REQ-046 RX 00 7F A5 FF FF 02 AA BB csum 9B -> leading bytes ignored; writes AA@FFFF, BB@0000; ACK.
REQ-047 A5 12 00 then silence for TIMEOUT_CYCLES -> error pulse, no TX write, busy low; next good frame accepted.
REQ-048 Status bit1 held 0 at reply time -> TX_STAT polling repeats, no wr; bit1 set -> exactly one wr of 06.
REQ-049 Throughout all scenarios: acia_rd and acia_wr are never high together, and every strobe is exactly one cycle wide.
